crc8_tx_framer: RTL
===================

Name: crc8_tx_framer

Overview:
Transmit-side framer that sits directly upstream of the CRC-8 receiver stage. It accepts a BW-bit payload on a valid/ready handshake and computes CRC-8 bit-serially, MSB first, using an LFSR. It then emits the codeword {payload, crc} on a registered bus that the receiver samples every cycle. With correct framing, the receiver's CRC over the full codeword is zero.

Parameters:
BW, 40, payload width in bits; BW >= 2.
CRC_BW, 8, CRC width.
POLY, 8'h07, generator polynomial x^8+x^2+x+1 with the implicit x^8 omitted; CRC_BW bits wide.

Ports:
clk  input  1  clock; all state updates on posedge.
rstn  input  1  synchronous, active-low reset.
in_data  input  BW  payload to frame.
in_valid  input  1  payload valid.
in_ready  output  1  framer can accept; combinational, equals (state==IDLE).
inject_err  input  1  sampled with the payload; when 1, bit 0 of the emitted CRC is inverted (fault injection for the downstream checker).
out  output  BW+CRC_BW  codeword {payload, crc}; payload in [BW+CRC_BW-1:CRC_BW], crc in [CRC_BW-1:0]; held between frames.
out_valid  output  1  one-cycle pulse, high in the cycle a new codeword first appears on out.

Behaviour:
- Reset (rstn==0 at posedge): state=IDLE, out=0, out_valid=0, crc=0, counter=0. Reset takes priority over everything, including mid-SHIFT; any partial frame is dropped and no out_valid is produced for it.
- CRC convention: init 0, no input/output reflection, no final XOR, payload bit BW-1 processed first.
- State IDLE: in_ready=1. On an edge with in_valid=1:
  - capture in_data into payload_q and shift_q;
  - capture inject_err into inj_q;
  - set crc=0 and cnt=BW-1;
  - go to SHIFT.
  If in_valid=0, stay in IDLE. out_valid is 0 every cycle except the pulse below.
- State SHIFT: in_ready=0 and in_valid is ignored; no data is lost because the source must hold its payload. Each edge performs one LFSR step:
  - fb = crc[CRC_BW-1] ^ shift_q[BW-1];
  - crc <= {crc[CRC_BW-2:0],1'b0} ^ (fb ? POLY : 0);
  - shift_q <= shift_q<<1;
  - cnt <= cnt-1.
- Last step (cnt==0 at the edge): compute crc_next as above, then:
  - out <= {payload_q, crc_next ^ {{(CRC_BW-1){1'b0}}, inj_q}};
  - out_valid <= 1;
  - state goes to IDLE.
- out_valid is cleared on the next edge.
- Latency: handshake at edge E0, and the codeword is visible after edge E(BW), i.e. BW cycles later. in_ready is high in the cycle after E(BW), which is the same cycle out_valid is high. Throughput is one frame per BW+1 cycles.
- Back-to-back frames: if in_valid is held, a new frame is accepted at the edge immediately following the out_valid cycle's start (E(BW+1)). out holds the previous codeword until that new frame completes.
- Counter width is $clog2(BW). cnt never wraps, because the SHIFT exit occurs at 0.
- Zero payload yields crc=0, so out=0. This is indistinguishable on the bus from reset; that is acceptable because the receiver treats it as a valid zero word.

Decomposition:
- Package crc_pkg holds:
  - localparam CRC8_POLY = 8'h07;
  - the state enum {IDLE, SHIFT}, encoded in 1 bit.
- Sub-module crc_lfsr_step (combinational): inputs crc, data_bit, poly; output crc_next. It is instantiated once. A word-parallel CRC can later reuse this module in a generate loop.

Test Plan:
- Reset mid-frame: accept 40'h00_0000_0001, assert rstn=0 at the 10th SHIFT edge -> out=0, out_valid=0, in_ready=1 after release, and no out_valid pulse follows.
- Single frame, payload 40'h00_0000_0001, inject_err=0 -> out_valid pulses exactly 40 cycles after the handshake edge; out=48'h00_0000_0001_07.
- Payload 40'h00_0000_0080 -> out=48'h00_0000_0080_89. Payload 40'h00_0000_0100 -> out=48'h00_0000_0100_15.
- Fault injection: payload 40'h00_0000_0001 with inject_err=1 -> out=48'h00_0000_0001_06. Feeding this to the receiver yields 0; feeding the injection-free codeword yields 40'h1.
- Busy/back-to-back: in_valid held high with 40'hAA and then 40'h55 presented -> in_ready=0 for 40 cycles after each accept; the second handshake lands on the edge after the first out_valid cycle begins; exactly two out_valid pulses occur, 41 cycles apart. Both codewords check to zero through a bit-serial reference model.
- Random regression: 1000 random payloads -> each out[7:0] matches the reference CRC-8/0x07 model, and the receiver output equals the payload.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC-8 transmit framer.
//   CRC8_POLY : generator x^8+x^2+x+1. The implicit x^8 term is dropped.
//   state_e   : framer FSM states, 1-bit encoded.
package crc_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// One bit-serial CRC LFSR step (MSB first, no reflection). This block is purely combinational.
// Ports:
//   crc      in  CRC_BW  current CRC register
//   data_bit in  1       next message bit
//   poly     in  CRC_BW  generator polynomial without the leading term
//   crc_next out CRC_BW  CRC after absorbing data_bit
module crc_lfsr_step #(
  parameter int unsigned CRC_BW = 8
) (
  input  logic [CRC_BW-1:0] crc,
  input  logic              data_bit,
  input  logic [CRC_BW-1:0] poly,
  output logic [CRC_BW-1:0] crc_next
);

  logic w_fb;

  assign w_fb     = crc[CRC_BW-1] ^ data_bit;
  assign crc_next = {crc[CRC_BW-2:0], 1'b0} ^ (w_fb ? poly : '0);

endmodule

// File: rtl/crc8_tx_framer.sv
// Transmit framer. It accepts a BW-bit payload on a valid/ready handshake.
// It computes the CRC-8 bit-serially (MSB first, init 0, no final XOR).
// It then presents the codeword {payload, crc} on a registered bus.
// Ports:
//   clk        in  1          clock, all state updates on posedge
//   rstn       in  1          synchronous active-low reset
//   in_data    in  BW         payload to frame
//   in_valid   in  1          payload valid
//   in_ready   out 1          high while idle (combinational)
//   inject_err in  1          sampled with payload; flips bit 0 of the emitted CRC
//   out        out BW+CRC_BW  codeword, held between frames
//   out_valid  out 1          one-cycle pulse when a new codeword appears on out
module crc8_tx_framer
  import crc_pkg::*;
#(
  parameter int unsigned       BW     = 40,
  parameter int unsigned       CRC_BW = 8,
  parameter logic [CRC_BW-1:0] POLY   = CRC_BW'(CRC8_POLY)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 inject_err,
  output logic [BW+CRC_BW-1:0] out,
  output logic                 out_valid
);

  localparam int unsigned CntW = $clog2(BW);

  state_e                r_state;
  logic [BW-1:0]         r_payload;
  logic [BW-1:0]         r_shift;
  logic                  r_inj;
  logic [CRC_BW-1:0]     r_crc;
  logic [CntW-1:0]       r_cnt;
  logic [BW+CRC_BW-1:0]  r_out;
  logic                  r_out_valid;

  logic [CRC_BW-1:0]     w_crc_next;
  logic [CRC_BW-1:0]     w_crc_final;

  crc_lfsr_step #(
    .CRC_BW (CRC_BW)
  ) u_step (
    .crc      (r_crc),
    .data_bit (r_shift[BW-1]),
    .poly     (POLY),
    .crc_next (w_crc_next)
  );

  // Fault injection only disturbs the LSB of the emitted CRC. The internal LFSR is unaffected.
  assign w_crc_final = w_crc_next ^ {{(CRC_BW-1){1'b0}}, r_inj};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_payload   <= '0;
      r_shift     <= '0;
      r_inj       <= 1'b0;
      r_crc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_payload <= in_data;
            r_shift   <= in_data;
            r_inj     <= inject_err;
            r_crc     <= '0;
            r_cnt     <= CntW'(BW - 1);
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_crc   <= w_crc_next;
          r_shift <= r_shift << 1;
          // Exit on zero so that the counter never wraps.
          if (r_cnt == '0) begin
            r_out       <= {r_payload, w_crc_final};
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule
